ddfs_rot_ctrl: RTL and testbench

Sequencer for the DDFS coarse-LUT plus multi-stage rotator datapath. It runs the phase accumulator and splits the truncated phase into a coarse-LUT address and a 9-bit rotation word. It issues LUT reads, drives the rotator's per-stage enables, and emits a valid strobe aligned with the rotator's `xs`/`ys` outputs. It sits between the frequency-control interface and the LUT/rotator pair, and handles start, stop and drain so that no partially computed sample is ever flagged valid.

---
 rtl/ddfs_pkg.sv | 33 +++
 rtl/ddfs_lfsr_dither.sv | 21 ++
 rtl/ddfs_rot_ctrl.sv | 144 ++++++++++++++
 tb/tb_ddfs_rot_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared widths, latencies, FSM states, LFSR constants and the
// rotation-word segment helper for the DDFS rotator sequencer.
package ddfs_pkg;

  localparam int unsigned DEF_PHASE_W = 32;
  localparam int unsigned DEF_ADDR_W  = 7;
  localparam int unsigned DEF_ROT_W   = 9;
  localparam int unsigned DEF_LUT_LAT = 1;
  localparam int unsigned DEF_ROT_LAT = 4;
  localparam int unsigned SEG_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shift-left form: taps at bits 15,13,12,10
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Return 3-bit segment k (0 = LSB segment) of a rotation word
  function automatic logic [SEG_W-1:0] rot_seg(input logic [DEF_ROT_W-1:0] w,
                                              input logic [1:0] k);
    case (k)
      2'd0:    rot_seg = w[2:0];
      2'd1:    rot_seg = w[5:3];
      default: rot_seg = w[8:6];
    endcase
  endfunction

endpackage

// File: rtl/ddfs_lfsr_dither.sv
// 16-bit Fibonacci LFSR used as phase dither source.
// Only instantiated when DDFS_PHASE_DITHER_EN is defined.
module ddfs_lfsr_dither
  import ddfs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  // Advance one step per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/ddfs_rot_ctrl.sv
// DDFS coarse-LUT + rotator sequencer: phase accumulator, phase split,
// LUT read issue, stage enables, valid token and start/stop/drain FSM.
// Optional phase dither: define DDFS_PHASE_DITHER_EN.
module ddfs_rot_ctrl
  import ddfs_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned ROT_W   = DEF_ROT_W,
  parameter int unsigned LUT_LAT = DEF_LUT_LAT,
  parameter int unsigned ROT_LAT = DEF_ROT_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               fcw_valid,
  input  logic [PHASE_W-1:0] fcw,
  output logic               fcw_ready,
  input  logic [1:0]         stage_mask,
  output logic               lut_rd_en,
  output logic [ADDR_W-1:0]  lut_addr,
  output logic [ROT_W-1:0]   phi_rot,
  output logic [2:0]         rot_en,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned T_W     = ADDR_W + ROT_W;
  localparam int unsigned TOK_LAT = LUT_LAT + ROT_LAT;
  localparam int unsigned CNT_W   = $clog2(TOK_LAT + 1);

  state_t                          state;
  logic [PHASE_W-1:0]              phase;
  logic [PHASE_W-1:0]              fcw_active;
  logic [PHASE_W-1:0]              phase_eff;
  logic [CNT_W-1:0]                drain_cnt;
  logic [TOK_LAT:0]                tok_q;
  logic [LUT_LAT:0][ROT_W-1:0]     rot_q;
  logic [LUT_LAT:0][2:0]           en_q;
  logic [T_W-1:0]                  trunc;
  logic [ADDR_W-1:0]               addr_word;
  logic [ROT_W-1:0]                rot_word;
  logic [2:0]                      en_word;
  logic                            issue;

`ifdef DDFS_PHASE_DITHER_EN
  localparam int unsigned DITH_W = PHASE_W - ADDR_W - ROT_W;
  logic [LFSR_W-1:0]  lfsr;
  logic [PHASE_W-1:0] dith;

  ddfs_lfsr_dither u_dither (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_RUN),
    .lfsr  (lfsr)
  );

  // Add zero-extended low LFSR bits below the truncation point
  always_comb begin
    dith = '0;
    for (int i = 0; i < int'(DITH_W) && i < int'(LFSR_W); i++) dith[i] = lfsr[i];
    phase_eff = phase + dith;
  end
`else
  assign phase_eff = phase;
`endif

  // Phase split and stage-enable decode for the read being issued
  always_comb begin
    trunc     = phase_eff[PHASE_W-1 -: T_W];
    addr_word = trunc[T_W-1 -: ADDR_W];
    rot_word  = trunc[ROT_W-1:0];
    en_word   = {stage_mask[1] && (rot_seg(DEF_ROT_W'(rot_word), 2'd2) != '0),
                 stage_mask[0] && (rot_seg(DEF_ROT_W'(rot_word), 2'd1) != '0),
                 1'b1};
  end

  // A read is issued on every cycle the FSM will spend in RUN
  assign issue = ((state == ST_IDLE) && start) || ((state == ST_RUN) && !stop);

  assign lut_rd_en = tok_q[0];
  assign out_valid = tok_q[TOK_LAT];
  assign phi_rot   = rot_q[LUT_LAT];
  assign rot_en    = en_q[LUT_LAT];

  // FSM, accumulator, read issue, alignment delay lines and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      fcw_active <= '0;
      drain_cnt  <= '0;
      tok_q      <= '0;
      rot_q      <= '0;
      en_q       <= '0;
      lut_addr   <= '0;
      fcw_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fcw_ready <= 1'b1;
      done      <= 1'b0;

      if (fcw_valid && fcw_ready) fcw_active <= fcw;
      if (issue) begin
        phase    <= phase + fcw_active;
        lut_addr <= addr_word;
      end

      tok_q <= {tok_q[TOK_LAT-1:0], issue};
      rot_q <= {rot_q[LUT_LAT-1:0], issue ? rot_word : rot_q[0]};
      en_q  <= {en_q[LUT_LAT-1:0], issue ? en_word : 3'b000};

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(TOK_LAT);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == CNT_W'(1)) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddfs_rot_ctrl.sv
// Self-checking bench for ddfs_rot_ctrl (default build, no dither).
module tb_ddfs_rot_ctrl;

  localparam int unsigned LUT_LAT = 1;
  localparam int unsigned ROT_LAT = 4;
  localparam int unsigned LAT     = LUT_LAT + ROT_LAT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0, stop = 1'b0, fcw_valid = 1'b0;
  logic [31:0] fcw = '0;
  logic [1:0]  stage_mask = '0;
  logic        fcw_ready, lut_rd_en, out_valid, busy, done;
  logic [6:0]  lut_addr;
  logic [8:0]  phi_rot;
  logic [2:0]  rot_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddfs_rot_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .fcw_valid  (fcw_valid),
    .fcw        (fcw),
    .fcw_ready  (fcw_ready),
    .stage_mask (stage_mask),
    .lut_rd_en  (lut_rd_en),
    .lut_addr   (lut_addr),
    .phi_rot    (phi_rot),
    .rot_en     (rot_en),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  // Reference: each issued read is a token; history[n] is the token issued n cycles ago
  typedef struct packed {
    logic       rd;
    logic [6:0] addr;
    logic [8:0] rot;
    logic [2:0] en;
  } tok_t;

  tok_t        hist [0:7];
  int          m_state;   // 0 idle, 1 running, 2 draining
  logic [31:0] m_phase, m_fcw;
  int          m_left;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin : ref_model
    tok_t t;
    logic iss;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      m_state = 0; m_phase = '0; m_fcw = '0; m_left = 0; m_done = 1'b0;
    end else begin
      t   = '0;
      iss = (m_state == 0 && start) || (m_state == 1 && !stop);
      if (iss) begin
        t.rd   = 1'b1;
        t.addr = m_phase[31:25];
        t.rot  = m_phase[24:16];
        t.en   = {stage_mask[1] && (t.rot[8:6] != 0), stage_mask[0] && (t.rot[5:3] != 0), 1'b1};
        m_phase = m_phase + m_fcw;
      end
      if (fcw_valid) m_fcw = fcw;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t;
      m_done = 1'b0;
      case (m_state)
        0: if (start) m_state = 1;
        1: if (stop) begin m_state = 2; m_left = LAT; end
        default: begin
          m_left--;
          if (m_left == 0) begin m_state = 0; m_done = 1'b1; end
        end
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    start = 0; stop = 0; fcw_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_fcw(input logic [31:0] v);
    fcw = v; fcw_valid = 1;
    @(negedge clk);
    fcw_valid = 0;
  endtask

  task automatic drain_run(output bit ok);
    stop = 1;
    @(negedge clk);
    stop = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    checks++; if (fcw_ready !== 1'b1) begin errors++; $display("FAIL reset_fcw_ready: got %b expected 1", fcw_ready); end
    checks++;
    if ({lut_rd_en, lut_addr, phi_rot, rot_en, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b addr=%0h phi=%0h en=%b v=%b busy=%b done=%b expected all 0",
               lut_rd_en, lut_addr, phi_rot, rot_en, out_valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (lut_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL idle_quiet: got rd=%b valid=%b expected 0 0", lut_rd_en, out_valid);
      end
    end
  endtask

  task automatic test_ramp();
    int reads = 0, rots = 0, vfirst = -1;
    bit ok;
    stage_mask = 2'b11;
    load_fcw(32'h0001_0000);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (out_valid && vfirst < 0) vfirst = k;
      if (lut_rd_en) begin
        checks++;
        if (lut_addr !== 7'(reads / 512)) begin
          errors++; $display("FAIL ramp_addr: got %0d expected %0d", lut_addr, reads / 512);
        end
        reads++;
      end
      if (rot_en[0]) begin
        checks++;
        if (phi_rot !== 9'(rots % 512)) begin
          errors++; $display("FAIL ramp_phi: got %0d expected %0d", phi_rot, rots % 512);
        end
        rots++;
      end
      @(negedge clk);
    end
    checks++; if (vfirst != 6) begin errors++; $display("FAIL ramp_latency: got %0d expected 6", vfirst); end
    drain_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ramp_done: got timeout expected done"); end
  endtask

  task automatic test_stop();
    int nval = 0, nrd = 0, ndone = 0, last_v = -1, done_k = -1;
    logic busy_before = 1'b0, busy_at = 1'b1;
    start = 1; stop = 1;            // together in IDLE: start wins
    @(negedge clk);
    start = 0; stop = 0;
    for (int k = 1; k <= 60; k++) begin
      checks++;
      if (out_valid !== hist[LAT].rd || done !== m_done || busy !== (m_state != 0)) begin
        errors++;
        $display("FAIL stop_model k=%0d: got v=%b done=%b busy=%b expected v=%b done=%b busy=%b",
                 k, out_valid, done, busy, hist[LAT].rd, m_done, m_state != 0);
      end
      if (lut_rd_en) nrd++;
      if (out_valid) begin nval++; last_v = k; end
      if (done) begin ndone++; done_k = k; busy_at = busy; end
      if (!done && ndone == 0) busy_before = busy;
      start = (k == 10 || k == 22);   // ignored in RUN and in DRAIN
      stop  = (k == 20 || k == 40);   // second one ignored in IDLE
      @(negedge clk);
    end
    start = 0; stop = 0;
    checks++; if (nrd != 20) begin errors++; $display("FAIL stop_reads: got %0d expected 20", nrd); end
    checks++; if (nval != 20) begin errors++; $display("FAIL stop_valid_count: got %0d expected 20", nval); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL stop_done_count: got %0d expected 1", ndone); end
    checks++; if (done_k != last_v + 1) begin errors++; $display("FAIL stop_done_align: got %0d expected %0d", done_k, last_v + 1); end
    checks++; if (busy_at !== 1'b0 || busy_before !== 1'b1) begin
      errors++; $display("FAIL stop_busy: got at_done=%b before=%b expected 0 1", busy_at, busy_before);
    end
    checks++; if (busy !== 1'b0 || lut_rd_en !== 1'b0) begin
      errors++; $display("FAIL stop_idle: got busy=%b rd=%b expected 0 0", busy, lut_rd_en);
    end
  endtask

  task automatic test_enables();
    bit s70 = 0, s07 = 0, ok;
    apply_reset();
    stage_mask = 2'b01;
    load_fcw(32'h0007_0000);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= 16; k++) begin
      if (rot_en[0] && phi_rot == 9'o070) begin
        s70 = 1; checks++;
        if (rot_en !== 3'b011) begin errors++; $display("FAIL en_070: got %b expected 011", rot_en); end
      end
      if (rot_en[0] && phi_rot == 9'o007) begin
        s07 = 1; checks++;
        if (rot_en !== 3'b001) begin errors++; $display("FAIL en_007: got %b expected 001", rot_en); end
      end
      @(negedge clk);
    end
    checks++; if (!(s70 && s07)) begin errors++; $display("FAIL en_seen: got %b%b expected 11", s70, s07); end
    drain_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_done: got timeout expected done"); end
  endtask

  task automatic test_wrap();
    int exp_a [6] = '{0, 127, 0, 1, 2, 4};
    bit ok;
    apply_reset();
    load_fcw(32'hFE00_0000);
    fcw = 32'h0200_0000; fcw_valid = 1; start = 1;
    @(negedge clk);
    fcw_valid = 0; start = 0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (lut_addr !== 7'(exp_a[k-1])) begin
        errors++; $display("FAIL wrap_addr k=%0d: got %0d expected %0d", k, lut_addr, exp_a[k-1]);
      end
      if (k == 3) begin fcw = 32'h0400_0000; fcw_valid = 1; end
      else fcw_valid = 0;
      @(negedge clk);
    end
    fcw_valid = 0;
    drain_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got timeout expected done"); end

    apply_reset();
    load_fcw(32'hFFFF_FFFF);
    fcw = 32'h8000_0000; fcw_valid = 1; start = 1;
    @(negedge clk);
    fcw_valid = 0; start = 0;
    @(negedge clk);
    checks++; if (lut_addr !== 7'd127) begin errors++; $display("FAIL wrap_hi_addr: got %0d expected 127", lut_addr); end
    @(negedge clk);
    checks++; if (lut_addr !== 7'd63) begin errors++; $display("FAIL wrap_mod_addr: got %0d expected 63", lut_addr); end
    checks++; if (phi_rot !== 9'h1FF) begin errors++; $display("FAIL wrap_hi_phi: got %0h expected 1ff", phi_rot); end
    @(negedge clk);
    checks++; if (lut_addr !== 7'd127) begin errors++; $display("FAIL wrap_again_addr: got %0d expected 127", lut_addr); end
    drain_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap2_done: got timeout expected done"); end
  endtask

  task automatic test_midrun_reset();
    load_fcw(32'h0123_4567);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({lut_rd_en, lut_addr, phi_rot, rot_en, out_valid, busy, done} !== '0 || fcw_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: got rd=%b addr=%0h phi=%0h en=%b v=%b busy=%b done=%b rdy=%b expected 0s rdy=1",
               lut_rd_en, lut_addr, phi_rot, rot_en, out_valid, busy, done, fcw_ready);
    end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || lut_rd_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet: got v=%b rd=%b busy=%b expected 0 0 0", out_valid, lut_rd_en, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      checks++;
      if (lut_rd_en !== hist[0].rd || (hist[0].rd && lut_addr !== hist[0].addr)) begin
        errors++; $display("FAIL rand_read k=%0d: got rd=%b addr=%0d expected rd=%b addr=%0d",
                           k, lut_rd_en, lut_addr, hist[0].rd, hist[0].addr);
      end
      checks++;
      if (rot_en !== hist[LUT_LAT].en || (hist[LUT_LAT].rd && phi_rot !== hist[LUT_LAT].rot)) begin
        errors++; $display("FAIL rand_rot k=%0d: got phi=%0h en=%b expected phi=%0h en=%b",
                           k, phi_rot, rot_en, hist[LUT_LAT].rot, hist[LUT_LAT].en);
      end
      checks++;
      if (out_valid !== hist[LAT].rd || busy !== (m_state != 0) || done !== m_done || fcw_ready !== 1'b1) begin
        errors++; $display("FAIL rand_ctrl k=%0d: got v=%b busy=%b done=%b rdy=%b expected v=%b busy=%b done=%b rdy=1",
                           k, out_valid, busy, done, fcw_ready, hist[LAT].rd, m_state != 0, m_done);
      end
      if (k < 2960) begin
        start     = ($urandom_range(0, 19) == 0);
        stop      = ($urandom_range(0, 29) == 0);
        fcw_valid = ($urandom_range(0, 7) == 0);
        fcw       = $urandom;
        if ($urandom_range(0, 63) == 0) stage_mask = 2'($urandom_range(0, 3));
      end else begin
        start = 0; stop = 1; fcw_valid = 0;
      end
      @(negedge clk);
    end
    stop = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_end_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stop();
    test_enables();
    test_wrap();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
